// File: rtl/sram_march_bist_if.sv
// Shared SRAM port-0 bus between the BIST engine and the OpenRAM macros.
// The master drives address/data/enables; the slave returns flattened read data.
// One csb bit per macro; dout0 packs channel k at [k*DATA_W +: DATA_W].
interface sram_march_bist_if #(
  parameter int NUM_CH  = 16,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int WMASK_W = 4
);
  logic [ADDR_W-1:0]        addr0;
  logic [DATA_W-1:0]        din0;
  logic                     web0;
  logic [WMASK_W-1:0]       wmask0;
  logic [NUM_CH-1:0]        csb0;
  logic [NUM_CH*DATA_W-1:0] dout0;

  modport master (
    output addr0, din0, web0, wmask0, csb0,
    input  dout0
  );

  modport slave (
    input  addr0, din0, web0, wmask0, csb0,
    output dout0
  );
endinterface

// File: rtl/sram_march_bist.sv
// March C- BIST for one selected SRAM macro on a shared port-0 bus.
// 10*(last_addr+1) back-to-back ops, one drain cycle, then sticky done/pass.
// Start is ignored while busy; results hold until the next accepted start.
module sram_march_bist #(
  parameter int NUM_CH  = 16,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int WMASK_W = 4,
  parameter int ERR_W   = 16,
  // one spare code point so an out-of-range macro select can be flagged
  parameter int CH_W    = $clog2(NUM_CH + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [CH_W-1:0]    chan_sel,
  input  logic [ADDR_W-1:0]  last_addr,
  input  logic [DATA_W-1:0]  pattern,
  sram_march_bist_if.master  sram,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               cfg_err,
  output logic [ERR_W-1:0]   err_count,
  output logic [ADDR_W-1:0]  fail_addr,
  output logic [DATA_W-1:0]  fail_data,
  output logic [2:0]         fail_elem
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state;
  logic [2:0]          elem;     // March element of the op on the bus (0..5)
  logic                ph;       // 0: read op, 1: write op
  logic [CH_W-1:0]     chan_q;
  logic [ADDR_W-1:0]   last_q;
  logic [DATA_W-1:0]   pat_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   din_q;
  logic                web_q;
  logic [WMASK_W-1:0]  wmask_q;
  logic [NUM_CH-1:0]   csb_q;

  // read issued last cycle, waiting for its data
  logic                rd_vld;
  logic [ADDR_W-1:0]   rd_addr;
  logic [2:0]          rd_elem;
  logic [DATA_W-1:0]   rd_exp;

  logic [2:0]          elem_n;
  logic                ph_n;
  logic [ADDR_W-1:0]   addr_n;
  logic                walk_end;
  logic                desc;
  logic                at_end;
  logic [DATA_W-1:0]   dout_sel;
  logic                mism;

  assign sram.addr0  = addr_q;
  assign sram.din0   = din_q;
  assign sram.web0   = web_q;
  assign sram.wmask0 = wmask_q;
  assign sram.csb0   = csb_q;

  // Write data: M1/M3 write ~pattern, M0/M2/M4 write pattern
  function automatic logic [DATA_W-1:0] wr_val(input logic [2:0] e, input logic [DATA_W-1:0] p);
    return (e == 3'd1 || e == 3'd3) ? ~p : p;
  endfunction

  // Next op of the march walk: finish a read/write pair, step address, or change element
  always_comb begin
    desc     = (elem >= 3'd3);
    at_end   = desc ? (addr_q == '0) : (addr_q == last_q);
    elem_n   = elem;
    ph_n     = 1'b1;
    addr_n   = addr_q;
    walk_end = 1'b0;
    if (!ph && elem != 3'd5) begin
      ph_n = 1'b1;
    end else if (!at_end) begin
      addr_n = desc ? addr_q - 1'b1 : addr_q + 1'b1;
      ph_n   = (elem == 3'd0);
    end else if (elem == 3'd5) begin
      walk_end = 1'b1;
    end else begin
      elem_n = elem + 3'd1;
      addr_n = (elem_n >= 3'd3) ? last_q : '0;
      ph_n   = 1'b0;
    end
  end

  // Pick the read data of the macro under test
  always_comb begin
    dout_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (chan_q == CH_W'(k)) dout_sel = sram.dout0[k*DATA_W +: DATA_W];
    end
  end

  assign mism = rd_vld && (dout_sel != rd_exp);

  // Control FSM, bus drive, compare pipeline and result capture
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      elem      <= '0;
      ph        <= 1'b0;
      chan_q    <= '0;
      last_q    <= '0;
      pat_q     <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      web_q     <= 1'b1;
      wmask_q   <= '0;
      csb_q     <= '1;
      rd_vld    <= 1'b0;
      rd_addr   <= '0;
      rd_elem   <= '0;
      rd_exp    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      cfg_err   <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      fail_data <= '0;
      fail_elem <= '0;
    end else begin
      rd_vld  <= (state == S_RUN) && !ph;
      rd_addr <= addr_q;
      rd_elem <= elem;
      rd_exp  <= (elem == 3'd2 || elem == 3'd4) ? ~pat_q : pat_q;
      if (mism) begin
        if (err_count != '1) err_count <= err_count + 1'b1;
        if (err_count == '0) begin
          fail_addr <= rd_addr;
          fail_data <= dout_sel;
          fail_elem <= rd_elem;
        end
      end
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (start) begin
            chan_q    <= chan_sel;
            last_q    <= last_addr;
            pat_q     <= pattern;
            done      <= 1'b0;
            pass      <= 1'b0;
            cfg_err   <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            fail_elem <= '0;
            if (int'(chan_sel) >= NUM_CH) begin
              state   <= S_DONE;
              done    <= 1'b1;
              cfg_err <= 1'b1;
            end else begin
              state   <= S_RUN;
              busy    <= 1'b1;
              elem    <= 3'd0;
              ph      <= 1'b1;
              addr_q  <= '0;
              din_q   <= pattern;
              web_q   <= 1'b0;
              wmask_q <= '1;
              csb_q   <= ~(NUM_CH'(1) << chan_sel);
            end
          end
        end
        S_RUN: begin
          if (walk_end) begin
            state   <= S_DRAIN;
            csb_q   <= '1;
            web_q   <= 1'b1;
            wmask_q <= '0;
          end else begin
            elem   <= elem_n;
            ph     <= ph_n;
            addr_q <= addr_n;
            web_q  <= ~ph_n;
            din_q  <= wr_val(elem_n, pat_q);
          end
        end
        S_DRAIN: begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_count == '0) && !mism;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: behavioural SRAM macros with fault injection,
// a bus-op scoreboard filled from the March C- element list, and a table of runs.
// Hand sequences cover reset state, start while busy and reset in the middle of M2.
module tb_sram_march_bist;
  localparam int NUM_CH = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int WMASK_W = 4;
  localparam int ERR_W = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic [4:0] chan_sel = '0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [DATA_W-1:0] pattern = '0;
  logic busy, done, pass, cfg_err;
  logic [ERR_W-1:0] err_count;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data;
  logic [2:0] fail_elem;

  always #5 clk = ~clk;

  sram_march_bist_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WMASK_W(WMASK_W)) bus ();

  sram_march_bist #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WMASK_W(WMASK_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .chan_sel(chan_sel), .last_addr(last_addr),
    .pattern(pattern), .sram(bus.master), .busy(busy), .done(done), .pass(pass),
    .cfg_err(cfg_err), .err_count(err_count), .fail_addr(fail_addr), .fail_data(fail_data),
    .fail_elem(fail_elem)
  );

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // SRAM macros: synchronous write, registered read data one cycle later
  logic [DATA_W-1:0] mem [NUM_CH][16];
  logic [DATA_W-1:0] dout_r [NUM_CH];
  logic [ADDR_W-1:0] raddr_r [NUM_CH];
  int fault_mode = 0;  // 0 none, 1 stuck-at-1 bit 0 at address 5, 2 reads return 0

  always @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (!bus.csb0[k]) begin
        if (!bus.web0) mem[k][bus.addr0] <= bus.din0;
        else begin
          dout_r[k]  <= mem[k][bus.addr0];
          raddr_r[k] <= bus.addr0;
        end
      end
    end
  end

  always_comb begin
    bus.dout0 = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (fault_mode == 2) bus.dout0[k*DATA_W +: DATA_W] = '0;
      else if (fault_mode == 1 && raddr_r[k] == 4'd5) bus.dout0[k*DATA_W +: DATA_W] = dout_r[k] | 32'h1;
      else bus.dout0[k*DATA_W +: DATA_W] = dout_r[k];
    end
  end

  // Scoreboard of expected bus ops
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              web;
    logic [DATA_W-1:0] din;
  } op_t;
  op_t exp_q[$];
  logic [NUM_CH-1:0] exp_csb = '1;
  int ops_seen = 0;

  task automatic push_op(input int a, input logic web, input logic [DATA_W-1:0] d);
    op_t o;
    o.addr = ADDR_W'(a);
    o.web  = web;
    o.din  = web ? '0 : d;
    exp_q.push_back(o);
  endtask

  task automatic build_ops(input int last, input logic [DATA_W-1:0] p);
    for (int a = 0; a <= last; a++) push_op(a, 1'b0, p);
    for (int a = 0; a <= last; a++) begin push_op(a, 1'b1, '0); push_op(a, 1'b0, ~p); end
    for (int a = 0; a <= last; a++) begin push_op(a, 1'b1, '0); push_op(a, 1'b0, p); end
    for (int a = last; a >= 0; a--) begin push_op(a, 1'b1, '0); push_op(a, 1'b0, ~p); end
    for (int a = last; a >= 0; a--) begin push_op(a, 1'b1, '0); push_op(a, 1'b0, p); end
    for (int a = last; a >= 0; a--) push_op(a, 1'b1, '0);
  endtask

  // Bus monitor: every op cycle is popped and compared
  always @(negedge clk) begin
    if (rstn && bus.csb0 != '1) begin
      op_t got;
      op_t want;
      ops_seen++;
      got.addr = bus.addr0;
      got.web  = bus.web0;
      got.din  = bus.web0 ? '0 : bus.din0;
      if (exp_q.size() == 0) begin
        chk("unexpected_op", 64'(got), 64'hDEAD);
      end else begin
        want = exp_q.pop_front();
        chk("bus_op", 64'(got), 64'(want));
        chk("csb_wmask", {44'(bus.csb0), 20'(bus.wmask0)}, {44'(exp_csb), 20'hF});
      end
    end
  end

  typedef struct {
    logic [4:0]        chan;
    logic [ADDR_W-1:0] last;
    logic [DATA_W-1:0] pat;
    int                fault;
    logic              exp_pass;
    logic              exp_cfg;
    logic [ERR_W-1:0]  exp_err;
    logic [ADDR_W-1:0] exp_faddr;
    logic [DATA_W-1:0] exp_fdata;
    logic [2:0]        exp_felem;
    int                exp_ops;
  } vec_t;

  task automatic run_vec(input vec_t v, input int inject);
    int cnt;
    fault_mode = v.fault;
    exp_q.delete();
    ops_seen = 0;
    exp_csb = ~(16'h1 << v.chan);
    if (v.chan < 5'd16) build_ops(int'(v.last), v.pat);
    @(negedge clk);
    start = 1'b1; chan_sel = v.chan; last_addr = v.last; pattern = v.pat;
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    while (!done && cnt < 4000) begin
      if (inject == 1 && cnt == 20) begin
        start = 1'b1; chan_sel = 5'd1; last_addr = 4'd2; pattern = '0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    chk("done_latency", 64'(cnt), 64'(v.exp_ops == 0 ? 1 : v.exp_ops + 2));
    chk("pass", 64'(pass), 64'(v.exp_pass));
    chk("cfg_err", 64'(cfg_err), 64'(v.exp_cfg));
    chk("err_count", 64'(err_count), 64'(v.exp_err));
    chk("fail_addr", 64'(fail_addr), 64'(v.exp_faddr));
    chk("fail_data", 64'(fail_data), 64'(v.exp_fdata));
    chk("fail_elem", 64'(fail_elem), 64'(v.exp_felem));
    chk("op_count", 64'(ops_seen), 64'(v.exp_ops));
    chk("ops_left", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    chk("done_sticky", {62'd0, done, busy}, 64'b10);
  endtask

  vec_t vt[7];

  initial begin
    int cnt;
    vt[0] = '{5'd3,  4'd7,  32'hA5A5A5A5, 0, 1'b1, 1'b0, 4'h0, 4'd0, 32'h0, 3'd0, 80};
    vt[1] = '{5'd3,  4'd7,  32'h00000000, 1, 1'b0, 1'b0, 4'h3, 4'd5, 32'h1, 3'd1, 80};
    vt[2] = '{5'd0,  4'd0,  32'h12345678, 0, 1'b1, 1'b0, 4'h0, 4'd0, 32'h0, 3'd0, 10};
    vt[3] = '{5'd15, 4'd15, 32'hFFFFFFFF, 2, 1'b0, 1'b0, 4'hF, 4'd0, 32'h0, 3'd1, 160};
    vt[4] = '{5'd16, 4'd7,  32'hA5A5A5A5, 0, 1'b0, 1'b1, 4'h0, 4'd0, 32'h0, 3'd0, 0};
    vt[5] = '{5'd5,  4'd0,  32'hFFFFFFFF, 2, 1'b0, 1'b0, 4'h3, 4'd0, 32'h0, 3'd1, 10};
    vt[6] = '{5'd7,  4'd3,  32'h00000000, 1, 1'b1, 1'b0, 4'h0, 4'd0, 32'h0, 3'd0, 40};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_bus", {7'd0, bus.csb0, bus.web0, bus.wmask0, bus.addr0, bus.din0},
        {7'd0, 16'hFFFF, 1'b1, 4'h0, 4'h0, 32'h0});
    chk("rst_flags", {60'd0, busy, done, pass, cfg_err}, 64'd0);
    chk("rst_fail", {9'd0, err_count, fail_addr, fail_data, fail_elem}, 64'd0);
    rstn = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vt[i], 0);

    // Start pulse while busy must not disturb the run
    run_vec(vt[0], 1);

    // Reset in the middle of M2 (N=8: M2 spans op cycles 25..40)
    fault_mode = 0;
    exp_q.delete();
    exp_csb = ~16'h0008;
    build_ops(7, 32'hA5A5A5A5);
    @(negedge clk);
    start = 1'b1; chan_sel = 5'd3; last_addr = 4'd7; pattern = 32'hA5A5A5A5;
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    while (cnt < 30) begin @(negedge clk); cnt++; end
    chk("mid_run_busy", 64'(busy), 64'd1);
    rstn = 1'b0;
    @(negedge clk);
    chk("rst_mid_run", {44'd0, bus.csb0, bus.web0, busy, done, 1'b0},
        {44'd0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0});
    exp_q.delete();
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", {62'd0, busy, done}, 64'd0);

    // Recovery run after the abort
    run_vec(vt[2], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
